// File: rtl/spmmio_router.sv
// ---------------------------------------------------------------------------
// spmmio_router
//
// Routes single Wishbone-style MMIO accesses to one of NUM_CH channels.
// adr_i[0:7] selects the channel and adr_i[8:23] is forwarded as the
// channel-local address. All vectors use ascending (big-endian) numbering,
// so bit 0 is the MSB.
//
// Channels whose WAIT_MASK bit is clear are "immediate": they are read after
// exactly one ACCESS cycle. Channels whose bit is set ("wait" channels)
// provide their own ch_ack. A wait access that gets no ack within TIMEOUT
// ACCESS cycles ends in an error response.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   adr_i, stb_i, cyc_i,
//   sel_i, we_i, dat_i  slave-side request
//   ack_o, err_o, dat_o slave-side response (registered)
//   ch_cs               one-hot channel select, held for the whole access
//   ch_adr, ch_sel,
//   ch_we, ch_d         latched request fields, held for the whole access
//   ch_ack              per-channel ack (only the selected bit is observed)
//   ch_q                per-channel read data, channel i at [32*i +: 32]
// ---------------------------------------------------------------------------
module spmmio_router #(
    parameter int unsigned NUM_CH    = 8,
    parameter logic [15:0] WAIT_MASK = 16'h0008,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:23]           adr_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    input  logic [0:3]            sel_i,
    input  logic                  we_i,
    input  logic [0:31]           dat_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [0:31]           dat_o,
    output logic [0:NUM_CH-1]     ch_cs,
    output logic [0:15]           ch_adr,
    output logic [0:3]            ch_sel,
    output logic                  ch_we,
    output logic [0:31]           ch_d,
    input  logic [0:NUM_CH-1]     ch_ack,
    input  logic [0:32*NUM_CH-1]  ch_q
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP,
        S_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              ack_o_q, ack_o_d;
    logic              err_o_q, err_o_d;
    logic [0:31]       dat_o_q, dat_o_d;
    logic [0:NUM_CH-1] ch_cs_q, ch_cs_d;
    logic [0:15]       ch_adr_q, ch_adr_d;
    logic [0:3]        ch_sel_q, ch_sel_d;
    logic              ch_we_q, ch_we_d;
    logic [0:31]       ch_d_q, ch_d_d;

    // Channel data and acks spread onto a fixed 16-entry view so that the
    // 4-bit channel index can select from them regardless of NUM_CH.
    logic [0:31] q_arr [16];
    logic [15:0] ack_vec;

    for (genvar g = 0; g < 16; g++) begin : g_ch
        if (g < NUM_CH) begin : g_used
            assign q_arr[g]   = ch_q[32*g +: 32];
            assign ack_vec[g] = ch_ack[g];
        end else begin : g_unused
            assign q_arr[g]   = '0;
            assign ack_vec[g] = 1'b0;
        end
    end

    logic        is_wait;
    logic        ack_sel;
    logic [0:31] q_sel;
    logic        cs_on;

    assign is_wait = WAIT_MASK[idx_q];
    assign ack_sel = ack_vec[idx_q];
    assign q_sel   = q_arr[idx_q];

    // NOTE: every signal written here gets a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        ack_o_d  = 1'b0;
        err_o_d  = 1'b0;
        dat_o_d  = dat_o_q;
        ch_adr_d = ch_adr_q;
        ch_sel_d = ch_sel_q;
        ch_we_d  = ch_we_q;
        ch_d_d   = ch_d_q;
        cs_on    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // stb_i alone (cyc_i low) is not a request.
                if (cyc_i && stb_i) begin
                    ch_adr_d = adr_i[8:23];
                    ch_sel_d = sel_i;
                    ch_we_d  = we_i;
                    ch_d_d   = dat_i;
                    idx_d    = adr_i[4:7];
                    if (adr_i[0:7] < 8'(NUM_CH)) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        cs_on   = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        err_o_d = 1'b1;
                        dat_o_d = '0;
                    end
                end
            end

            S_ACCESS: begin
                if (!cyc_i) begin
                    // Master abandoned the cycle: silent return to IDLE.
                    state_d = S_IDLE;
                end else if (!is_wait || ack_sel) begin
                    // Ack is tested before the timeout so that an ack in
                    // the final allowed cycle still completes normally.
                    state_d = S_RESP;
                    ack_o_d = 1'b1;
                    dat_o_d = ch_we_q ? '0 : q_sel;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    err_o_d = 1'b1;
                    dat_o_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    cs_on = 1'b1;
                end
            end

            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
            ch_cs_d[i] = cs_on && (idx_d == 4'(i));
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Every register, including the latched request fields, returns
            // to zero so the channel side sees a clean bus after reset.
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            ack_o_q  <= 1'b0;
            err_o_q  <= 1'b0;
            dat_o_q  <= '0;
            ch_cs_q  <= '0;
            ch_adr_q <= '0;
            ch_sel_q <= '0;
            ch_we_q  <= 1'b0;
            ch_d_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            ack_o_q  <= ack_o_d;
            err_o_q  <= err_o_d;
            dat_o_q  <= dat_o_d;
            ch_cs_q  <= ch_cs_d;
            ch_adr_q <= ch_adr_d;
            ch_sel_q <= ch_sel_d;
            ch_we_q  <= ch_we_d;
            ch_d_q   <= ch_d_d;
        end
    end

    assign ack_o  = ack_o_q;
    assign err_o  = err_o_q;
    assign dat_o  = dat_o_q;
    assign ch_cs  = ch_cs_q;
    assign ch_adr = ch_adr_q;
    assign ch_sel = ch_sel_q;
    assign ch_we  = ch_we_q;
    assign ch_d   = ch_d_q;

endmodule

// File: tb/tb_spmmio_router.sv
// ---------------------------------------------------------------------------
// tb_spmmio_router
//
// Self-checking bench for spmmio_router with default parameters.
// Directed table of transactions, hand-written multi-cycle corner cases
// (abort, reset mid-access, stb without cyc, back-to-back), then random
// transactions whose outcome comes from a transaction-level model.
// ---------------------------------------------------------------------------
module tb_spmmio_router;

    localparam int          NUM_CH    = 8;
    localparam logic [15:0] WAIT_MASK = 16'h0008;
    localparam int          TIMEOUT   = 255;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [0:23]          adr_i;
    logic                 stb_i;
    logic                 cyc_i;
    logic [0:3]           sel_i;
    logic                 we_i;
    logic [0:31]          dat_i;
    logic                 ack_o;
    logic                 err_o;
    logic [0:31]          dat_o;
    logic [0:NUM_CH-1]    ch_cs;
    logic [0:15]          ch_adr;
    logic [0:3]           ch_sel;
    logic                 ch_we;
    logic [0:31]          ch_d;
    logic [0:NUM_CH-1]    ch_ack;
    logic [0:32*NUM_CH-1] ch_q;

    spmmio_router #(
        .NUM_CH   (NUM_CH),
        .WAIT_MASK(WAIT_MASK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .adr_i (adr_i),
        .stb_i (stb_i),
        .cyc_i (cyc_i),
        .sel_i (sel_i),
        .we_i  (we_i),
        .dat_i (dat_i),
        .ack_o (ack_o),
        .err_o (err_o),
        .dat_o (dat_o),
        .ch_cs (ch_cs),
        .ch_adr(ch_adr),
        .ch_sel(ch_sel),
        .ch_we (ch_we),
        .ch_d  (ch_d),
        .ch_ack(ch_ack),
        .ch_q  (ch_q)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] last_dat;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] adr_low;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] q;
        int          ack_delay;   // ACCESS cycle in which ch_ack rises, 0 = never
        bit          exp_err;
        int          exp_len;     // ACCESS cycles, 0 = decode error
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        bit          is_err;
        int          len;
        logic [31:0] dat;
    } pred_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cs_word(input logic [0:NUM_CH-1] v);
        return {{(32 - NUM_CH){1'b0}}, v};
    endfunction

    // Outcome of one access, straight from the routing rules.
    function automatic pred_t predict(input logic [7:0] idx, input logic we,
                                      input logic [31:0] q, input int ack_delay);
        pred_t p;
        if (int'(idx) >= NUM_CH) begin
            p = '{1'b1, 0, 32'h0};
        end else if (!WAIT_MASK[idx[3:0]]) begin
            p = '{1'b0, 1, we ? 32'h0 : q};
        end else if (ack_delay >= 1 && ack_delay <= TIMEOUT) begin
            p = '{1'b0, ack_delay, we ? 32'h0 : q};
        end else begin
            p = '{1'b1, TIMEOUT, 32'h0};
        end
        return p;
    endfunction

    task automatic fill_q(input logic [7:0] idx, input logic [31:0] q);
        for (int i = 0; i < NUM_CH; i++) ch_q[32*i +: 32] = $urandom();
        if (int'(idx) < NUM_CH) ch_q[32*int'(idx) +: 32] = q;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ack_o"},  {31'b0, ack_o}, 32'h0);
        check({tag, ".err_o"},  {31'b0, err_o}, 32'h0);
        check({tag, ".dat_o"},  dat_o, 32'h0);
        check({tag, ".ch_cs"},  cs_word(ch_cs), 32'h0);
        check({tag, ".ch_adr"}, {16'b0, ch_adr}, 32'h0);
        check({tag, ".ch_sel"}, {28'b0, ch_sel}, 32'h0);
        check({tag, ".ch_we"},  {31'b0, ch_we}, 32'h0);
        check({tag, ".ch_d"},   ch_d, 32'h0);
    endtask

    // Drives one request from IDLE and follows it cycle by cycle until the
    // DUT is back in IDLE. Expected timing comes from exp_len/exp_err.
    task automatic run_txn(input string tag, input vec_t v);
        logic [0:NUM_CH-1] cs_exp;
        logic              is_wait;
        cs_exp  = '0;
        is_wait = 1'b0;
        if (int'(v.idx) < NUM_CH) begin
            cs_exp[int'(v.idx)] = 1'b1;
            is_wait = WAIT_MASK[v.idx[3:0]];
        end
        fill_q(v.idx, v.q);
        adr_i  = {v.idx, v.adr_low};
        we_i   = v.we;
        sel_i  = v.sel;
        dat_i  = v.dat;
        cyc_i  = 1'b1;
        stb_i  = 1'b1;
        ch_ack = '0;
        tick();
        // Request fields change after acceptance; outputs must not follow.
        stb_i = 1'b0;
        adr_i = 24'($urandom());
        dat_i = $urandom();
        sel_i = 4'($urandom());
        check({tag, ".ch_adr"}, {16'b0, ch_adr}, {16'b0, v.adr_low});
        check({tag, ".ch_sel"}, {28'b0, ch_sel}, {28'b0, v.sel});
        check({tag, ".ch_we"},  {31'b0, ch_we}, {31'b0, v.we});
        if (v.exp_len == 0) begin
            check({tag, ".dec_cs"},  cs_word(ch_cs), 32'h0);
            check({tag, ".dec_err"}, {31'b0, err_o}, 32'h1);
            check({tag, ".dec_ack"}, {31'b0, ack_o}, 32'h0);
            check({tag, ".dec_dat"}, dat_o, v.exp_dat);
        end else begin
            for (int n = 1; n <= v.exp_len; n++) begin
                check({tag, ".cs_hold"},  cs_word(ch_cs), cs_word(cs_exp));
                check({tag, ".ch_d"},     ch_d, v.dat);
                check({tag, ".busy_rsp"}, {30'b0, ack_o, err_o}, 32'h0);
                check({tag, ".dat_hold"}, dat_o, last_dat);
                ch_ack = NUM_CH'($urandom());
                ch_ack[int'(v.idx)] = is_wait && (n == v.ack_delay);
                tick();
            end
            check({tag, ".end_cs"},  cs_word(ch_cs), 32'h0);
            check({tag, ".end_ack"}, {31'b0, ack_o}, {31'b0, !v.exp_err});
            check({tag, ".end_err"}, {31'b0, err_o}, {31'b0, v.exp_err});
            check({tag, ".end_dat"}, dat_o, v.exp_dat);
        end
        last_dat = v.exp_dat;
        ch_ack   = '0;
        cyc_i    = 1'b0;
        tick();
        check({tag, ".idle_rsp"}, {30'b0, ack_o, err_o}, 32'h0);
        check({tag, ".idle_cs"},  cs_word(ch_cs), 32'h0);
        check({tag, ".idle_dat"}, dat_o, last_dat);
    endtask

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t  v;
        pred_t p;

        //              idx    adr_low   we    sel   dat            q              dly  err len  exp_dat
        tbl.push_back('{8'h00, 16'h0004, 1'b0, 4'hF, 32'h0,         32'hDEADBEEF,  0,   0,  1,   32'hDEADBEEF});
        tbl.push_back('{8'h03, 16'h0120, 1'b1, 4'h3, 32'hCAFE0003,  32'h55555555,  5,   0,  5,   32'h0});
        tbl.push_back('{8'h07, 16'hFFFC, 1'b0, 4'h1, 32'h0,         32'h12345678,  0,   0,  1,   32'h12345678});
        tbl.push_back('{8'h03, 16'h0200, 1'b0, 4'hF, 32'h0,         32'h77777777,  0,   1,  255, 32'h0});
        tbl.push_back('{8'h03, 16'h0204, 1'b0, 4'hF, 32'h0,         32'h13572468,  255, 0,  255, 32'h13572468});
        tbl.push_back('{8'h0A, 16'h0008, 1'b0, 4'hF, 32'h01020304,  32'h0,         0,   1,  0,   32'h0});
        tbl.push_back('{8'h03, 16'h0300, 1'b0, 4'hF, 32'h0,         32'h87654321,  1,   0,  1,   32'h87654321});
        tbl.push_back('{8'h08, 16'h0000, 1'b1, 4'hF, 32'hFFFFFFFF,  32'h0,         0,   1,  0,   32'h0});
        tbl.push_back('{8'h01, 16'h0010, 1'b1, 4'hC, 32'h0BADF00D,  32'hAAAAAAAA,  0,   0,  1,   32'h0});
        tbl.push_back('{8'h05, 16'h0044, 1'b0, 4'h8, 32'h0,         32'h0F0F0F0F,  0,   0,  1,   32'h0F0F0F0F});
        tbl.push_back('{8'hFF, 16'hABCD, 1'b0, 4'hF, 32'h11111111,  32'h0,         0,   1,  0,   32'h0});
        tbl.push_back('{8'h03, 16'h0400, 1'b0, 4'hF, 32'h0,         32'h2468ACE0,  254, 0,  254, 32'h2468ACE0});

        reset  = 1'b1;
        adr_i  = '0;
        stb_i  = 1'b0;
        cyc_i  = 1'b0;
        sel_i  = '0;
        we_i   = 1'b0;
        dat_i  = '0;
        ch_ack = '0;
        ch_q   = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset    = 1'b0;
        last_dat = 32'h0;
        tick();

        // Directed table.
        foreach (tbl[i]) run_txn($sformatf("tbl%0d", i), tbl[i]);

        // stb without cyc is ignored.
        adr_i = 24'h000010;
        stb_i = 1'b1;
        tick();
        tick();
        check("stb_only.cs",  cs_word(ch_cs), 32'h0);
        check("stb_only.rsp", {30'b0, ack_o, err_o}, 32'h0);
        stb_i = 1'b0;
        tick();

        // Abort: cyc_i drops during a wait access.
        fill_q(8'h03, 32'h99999999);
        adr_i = 24'h030040;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        tick();
        stb_i = 1'b0;
        check("abort.cs_on", cs_word(ch_cs), 32'h0000_0010);
        tick();
        cyc_i = 1'b0;
        tick();
        check("abort.cs_off", cs_word(ch_cs), 32'h0);
        check("abort.rsp0",   {30'b0, ack_o, err_o}, 32'h0);
        tick();
        check("abort.rsp1",   {30'b0, ack_o, err_o}, 32'h0);
        check("abort.dat",    dat_o, last_dat);
        run_txn("post_abort", '{8'h02, 16'h0020, 1'b0, 4'hF, 32'h0, 32'h31415926, 0, 0, 1, 32'h31415926});

        // Reset in the middle of a wait access.
        fill_q(8'h03, 32'h44444444);
        adr_i = 24'h03ABCD;
        we_i  = 1'b1;
        sel_i = 4'hF;
        dat_i = 32'hA5A5A5A5;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        tick();
        stb_i = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        cyc_i = 1'b0;
        tick();
        check("mid_reset.rsp", {30'b0, ack_o, err_o}, 32'h0);
        last_dat = 32'h0;
        run_txn("post_reset", '{8'h03, 16'h0008, 1'b0, 4'hF, 32'h0, 32'h600DF00D, 3, 0, 3, 32'h600DF00D});

        // Back-to-back immediate reads with cyc/stb held: one per 3 cycles.
        fill_q(8'h00, 32'h11223344);
        adr_i = 24'h000000;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            check($sformatf("b2b%0d.cs", t),  cs_word(ch_cs), (t % 3 == 1) ? 32'h80 : 32'h0);
            check($sformatf("b2b%0d.ack", t), {31'b0, ack_o}, {31'b0, t % 3 == 2});
        end
        cyc_i = 1'b0;
        stb_i = 1'b0;
        tick();
        check("b2b.dat", dat_o, 32'h11223344);
        last_dat = 32'h11223344;

        // Random transactions against the model.
        for (int k = 0; k < 40; k++) begin
            v.idx = 8'($urandom_range(0, 11));
            if ($urandom_range(0, 2) == 0) v.idx = 8'h03;
            if ($urandom_range(0, 15) == 0) v.idx = 8'($urandom());
            v.adr_low = 16'($urandom());
            v.we      = 1'($urandom());
            v.sel     = 4'($urandom());
            v.dat     = $urandom();
            v.q       = $urandom();
            v.ack_delay = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            p = predict(v.idx, v.we, v.q, v.ack_delay);
            v.exp_err = p.is_err;
            v.exp_len = p.len;
            v.exp_dat = p.dat;
            run_txn($sformatf("rnd%0d", k), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
